// File: rtl/mem_access_ctrl.sv
// Y86-64 memory-stage access controller: decodes the M-stage icode into a
// data-memory transaction and runs a req/ack handshake with stall, timeout and error status.
module mem_access_ctrl #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int ICODE_W   = 4,
  parameter int ALIGN_CHK = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               M_valid_i,
  input  logic [ICODE_W-1:0] M_icode_i,
  input  logic [DATA_W-1:0]  M_valE_i,
  input  logic [DATA_W-1:0]  M_valA_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic               mem_ack_i,
  input  logic               mem_err_i,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic               m_stall_o,
  output logic               m_done_o,
  output logic [DATA_W-1:0]  m_valM_o,
  output logic               m_adr_err_o
);

  localparam logic [ICODE_W-1:0] I_RMMOVQ = ICODE_W'(4'h4);
  localparam logic [ICODE_W-1:0] I_MRMOVQ = ICODE_W'(4'h5);
  localparam logic [ICODE_W-1:0] I_CALL   = ICODE_W'(4'h8);
  localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'(4'h9);
  localparam logic [ICODE_W-1:0] I_PUSHQ  = ICODE_W'(4'hA);
  localparam logic [ICODE_W-1:0] I_POPQ   = ICODE_W'(4'hB);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(DATA_W / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              is_rd;
  logic              is_wr;
  logic [ADDR_W-1:0] addr_d;
  logic              start;
  logic              misal;

  always_comb begin
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    addr_d = ADDR_W'(M_valE_i);
    case (M_icode_i)
      I_RMMOVQ, I_PUSHQ, I_CALL: is_wr = 1'b1;
      I_MRMOVQ:                  is_rd = 1'b1;
      I_POPQ, I_RET: begin
        is_rd  = 1'b1;
        addr_d = ADDR_W'(M_valA_i);
      end
      default: ;
    endcase
  end

  assign start = M_valid_i && (is_rd || is_wr);
  assign misal = (ALIGN_CHK != 0) && ((addr_d & AMASK) != '0);

  // Reset forces stall low even while a start is presented.
  assign m_stall_o = !rst &&
    (((state == S_IDLE) && start) || (state == S_REQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      m_done_o    <= 1'b0;
      m_adr_err_o <= 1'b0;
      m_valM_o    <= '0;
    end else begin
      m_done_o    <= 1'b0;
      m_adr_err_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (misal) begin
              state       <= S_ERR;
              m_done_o    <= 1'b1;
              m_adr_err_o <= 1'b1;
            end else begin
              state       <= S_REQ;
              cnt         <= '0;
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_wr;
              mem_addr_o  <= addr_d;
              mem_wdata_o <= M_valA_i;
            end
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            m_done_o  <= 1'b1;
            if (mem_err_i) begin
              state       <= S_ERR;
              m_adr_err_o <= 1'b1;
            end else begin
              state <= S_DONE;
              if (!mem_we_o) m_valM_o <= mem_rdata_i;
            end
          end else if ((TIMEOUT != 0) && (cnt == TLAST)) begin
            state       <= S_ERR;
            mem_req_o   <= 1'b0;
            m_done_o    <= 1'b1;
            m_adr_err_o <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; a second instance with the alignment
// check disabled runs in lockstep on the same inputs.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid_i;
  logic [3:0]  M_icode_i;
  logic [63:0] M_valE_i;
  logic [63:0] M_valA_i;
  logic        mem_ack_i;
  logic        mem_err_i;
  logic [63:0] mem_rdata_i;

  logic        req, we, stall, done, aerr;
  logic [63:0] addr, wdata, valm;
  logic        req2, we2, stall2, done2, aerr2;
  logic [63:0] addr2, wdata2, valm2;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_W(64), .ADDR_W(64), .ICODE_W(4),
    .ALIGN_CHK(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .M_valid_i(M_valid_i), .M_icode_i(M_icode_i),
    .M_valE_i(M_valE_i), .M_valA_i(M_valA_i),
    .mem_req_o(req), .mem_we_o(we),
    .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i),
    .m_stall_o(stall), .m_done_o(done),
    .m_valM_o(valm), .m_adr_err_o(aerr)
  );

  mem_access_ctrl #(
    .DATA_W(64), .ADDR_W(64), .ICODE_W(4),
    .ALIGN_CHK(0), .TIMEOUT(4)
  ) dut2 (
    .clk(clk), .rst(rst),
    .M_valid_i(M_valid_i), .M_icode_i(M_icode_i),
    .M_valE_i(M_valE_i), .M_valA_i(M_valA_i),
    .mem_req_o(req2), .mem_we_o(we2),
    .mem_addr_o(addr2), .mem_wdata_o(wdata2),
    .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i),
    .m_stall_o(stall2), .m_done_o(done2),
    .m_valM_o(valm2), .m_adr_err_o(aerr2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ic,
                       input logic [63:0] ve,
                       input logic [63:0] va);
    M_valid_i = 1'b1;
    M_icode_i = ic;
    M_valE_i  = ve;
    M_valA_i  = va;
  endtask

  task automatic idle_in();
    M_valid_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_err_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    M_valid_i = 1'b0;
    M_icode_i = 4'h1;
    M_valE_i = '0;
    M_valA_i = '0;
    mem_ack_i = 1'b0;
    mem_err_i = 1'b0;
    mem_rdata_i = '0;
    #12;
    chk("rst_req", {63'b0, req}, 64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_valm", valm, 64'd0);
    chk("rst_addr", addr, 64'd0);
    #5 rst = 1'b0;
    tick();

    // 1: MRMOVQ, ack in third REQ cycle
    issue(4'h5, 64'h100, 64'h0);
    #1;
    chk("t1_stall_accept", {63'b0, stall}, 64'd1);
    chk("t1_noreq_accept", {63'b0, req}, 64'd0);
    tick();
    chk("t1_req1", {63'b0, req}, 64'd1);
    chk("t1_addr", addr, 64'h100);
    chk("t1_we", {63'b0, we}, 64'd0);
    chk("t1_stall1", {63'b0, stall}, 64'd1);
    tick();
    chk("t1_req2", {63'b0, req}, 64'd1);
    tick();
    chk("t1_req3", {63'b0, req}, 64'd1);
    chk("t1_stall3", {63'b0, stall}, 64'd1);
    mem_ack_i = 1'b1;
    mem_rdata_i = 64'hDEADBEEF;
    tick();
    idle_in();
    chk("t1_done", {63'b0, done}, 64'd1);
    chk("t1_nostall", {63'b0, stall}, 64'd0);
    chk("t1_reqoff", {63'b0, req}, 64'd0);
    chk("t1_aerr", {63'b0, aerr}, 64'd0);
    chk("t1_valm", valm, 64'hDEADBEEF);
    tick();
    chk("t1_done_pulse", {63'b0, done}, 64'd0);

    // 2: RMMOVQ, ack in first REQ cycle
    issue(4'h4, 64'h208, 64'h55);
    #1;
    chk("t2_stall_accept", {63'b0, stall}, 64'd1);
    tick();
    chk("t2_req", {63'b0, req}, 64'd1);
    chk("t2_we", {63'b0, we}, 64'd1);
    chk("t2_addr", addr, 64'h208);
    chk("t2_wdata", wdata, 64'h55);
    mem_ack_i = 1'b1;
    mem_rdata_i = 64'h1111;
    tick();
    idle_in();
    chk("t2_done", {63'b0, done}, 64'd1);
    chk("t2_nostall", {63'b0, stall}, 64'd0);
    chk("t2_valm_kept", valm, 64'hDEADBEEF);
    tick();

    // 3: POPQ / RET read at valA, CALL writes at valE
    issue(4'hB, 64'h200, 64'h1F8);
    tick();
    chk("t3_pop_addr", addr, 64'h1F8);
    chk("t3_pop_we", {63'b0, we}, 64'd0);
    mem_ack_i = 1'b1;
    mem_rdata_i = 64'h1234;
    tick();
    idle_in();
    chk("t3_pop_valm", valm, 64'h1234);
    tick();
    issue(4'h9, 64'h200, 64'h1F8);
    tick();
    chk("t3_ret_addr", addr, 64'h1F8);
    chk("t3_ret_we", {63'b0, we}, 64'd0);
    mem_ack_i = 1'b1;
    mem_rdata_i = 64'h5678;
    tick();
    idle_in();
    chk("t3_ret_valm", valm, 64'h5678);
    tick();
    issue(4'h8, 64'h1F0, 64'h77);
    tick();
    chk("t3_call_addr", addr, 64'h1F0);
    chk("t3_call_we", {63'b0, we}, 64'd1);
    chk("t3_call_wdata", wdata, 64'h77);
    mem_ack_i = 1'b1;
    tick();
    idle_in();
    chk("t3_call_done", {63'b0, done}, 64'd1);
    tick();

    // 4: misaligned read; checked instance errors, unchecked one reads
    issue(4'h5, 64'h103, 64'h0);
    #1;
    chk("t4_stall", {63'b0, stall}, 64'd1);
    tick();
    chk("t4_noreq", {63'b0, req}, 64'd0);
    chk("t4_done", {63'b0, done}, 64'd1);
    chk("t4_aerr", {63'b0, aerr}, 64'd1);
    chk("t4_nostall", {63'b0, stall}, 64'd0);
    chk("t4_nc_req", {63'b0, req2}, 64'd1);
    chk("t4_nc_addr", addr2, 64'h103);
    M_valid_i = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = 64'hABCD;
    tick();
    idle_in();
    chk("t4_aerr_pulse", {63'b0, aerr}, 64'd0);
    chk("t4_valm_kept", valm, 64'h5678);
    chk("t4_nc_done", {63'b0, done2}, 64'd1);
    chk("t4_nc_aerr", {63'b0, aerr2}, 64'd0);
    chk("t4_nc_valm", valm2, 64'hABCD);
    tick();

    // 5a: timeout after four unanswered REQ cycles
    issue(4'h5, 64'h300, 64'h0);
    tick();
    chk("t5_req1", {63'b0, req}, 64'd1);
    tick();
    tick();
    tick();
    chk("t5_req4", {63'b0, req}, 64'd1);
    chk("t5_stall4", {63'b0, stall}, 64'd1);
    tick();
    M_valid_i = 1'b0;
    chk("t5_to_req", {63'b0, req}, 64'd0);
    chk("t5_to_done", {63'b0, done}, 64'd1);
    chk("t5_to_aerr", {63'b0, aerr}, 64'd1);
    tick();

    // 5b: bus error on ack
    issue(4'h5, 64'h308, 64'h0);
    tick();
    mem_ack_i = 1'b1;
    mem_err_i = 1'b1;
    mem_rdata_i = 64'hBAD;
    tick();
    idle_in();
    chk("t5_be_done", {63'b0, done}, 64'd1);
    chk("t5_be_aerr", {63'b0, aerr}, 64'd1);
    chk("t5_be_valm", valm, 64'h5678);
    tick();

    // 6: reset mid-REQ, then non-memory icode
    issue(4'h5, 64'h400, 64'h0);
    tick();
    chk("t6_req_pre", {63'b0, req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_rst", {63'b0, req}, 64'd0);
    chk("t6_stall_rst", {63'b0, stall}, 64'd0);
    chk("t6_valm_rst", valm, 64'd0);
    #2 rst = 1'b0;
    issue(4'h6, 64'h400, 64'h0);
    #1;
    chk("t6_opq_stall", {63'b0, stall}, 64'd0);
    tick();
    chk("t6_opq_req", {63'b0, req}, 64'd0);
    chk("t6_opq_done", {63'b0, done}, 64'd0);
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
